// File: rtl/pipeline_pkg.sv
// Shared fetch pipeline definitions: widths, line geometry, reset PC and fetch states.
package pipeline_pkg;

    localparam int PC_W       = 16;
    localparam int LINE_W     = 64;
    localparam int LINE_BYTES = 8;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Clear the within-line byte offset so the address points at a line start.
    function automatic logic [PC_W-1:0] align_line(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/imem_phase_tracker.sv
// Mirrors the instruction memory access phase. The memory has no handshake, so this
// counter restarts whenever the fetch address changes and flags data valid (dv) in the
// cycle where the count reaches MEM_LATENCY.
module imem_phase_tracker
    import pipeline_pkg::*;
#(
    parameter int MEM_LATENCY = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] addr_cur,
    input  logic [PC_W-1:0] addr_nxt,
    input  logic            restart,
    output logic            dv
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    logic [CNT_W-1:0] cnt;

    // Count cycles since the address last changed, wrapping to 1 after each valid phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (addr_nxt != addr_cur)) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == LAT) ? CNT_W'(1) : cnt + 1'b1;
        end
    end

    assign dv = (cnt == LAT);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// presents captured lines to decode through a valid/ready IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [LINE_W-1:0] imem_ins,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [PC_W-1:0]   if_pc,
    output logic [LINE_W-1:0] if_instr,
    output logic [31:0]       perf_lines,
    output logic [31:0]       perf_stalls
);

    fetch_state_t      state, state_nxt;
    logic [PC_W-1:0]   addr_nxt;
    logic              valid_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [LINE_W-1:0] instr_nxt;
    logic              capture;
    logic              dv;

    imem_phase_tracker #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_cur (imem_addr),
        .addr_nxt (addr_nxt),
        .restart  (state == PARK),
        .dv       (dv)
    );

    // Next-state and IF/ID update; redirect wins over capture, and a blocked line is
    // dropped and re-read on the next valid phase of the unchanged address.
    always_comb begin
        state_nxt = state;
        addr_nxt  = imem_addr;
        valid_nxt = if_valid;
        pc_nxt    = if_pc;
        instr_nxt = if_instr;
        capture   = 1'b0;
        case (state)
            PARK: begin
                addr_nxt  = RESET_PC;
                state_nxt = FETCH;
            end
            default: begin
                if (if_valid && if_ready) valid_nxt = 1'b0;
                if (state == HOLD && if_ready) state_nxt = FETCH;
                if (redirect_valid) begin
                    // The held line is flushed, so there is nothing left to wait on.
                    addr_nxt  = align_line(redirect_pc);
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (dv && state == FETCH) begin
                    if (!if_valid || if_ready) begin
                        capture   = 1'b1;
                        instr_nxt = imem_ins;
                        pc_nxt    = imem_addr;
                        valid_nxt = 1'b1;
                        addr_nxt  = imem_addr + PC_W'(LINE_BYTES);
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
        endcase
    end

    // State, address and IF/ID registers; reset parks memory on a different line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PARK;
            imem_addr <= RESET_PC + PC_W'(LINE_BYTES);
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
        end else begin
            state     <= state_nxt;
            imem_addr <= addr_nxt;
            if_valid  <= valid_nxt;
            if_pc     <= pc_nxt;
            if_instr  <= instr_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of captured lines and decode back-pressure cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lines  <= '0;
            perf_stalls <= '0;
        end else begin
            if (capture && perf_lines != 32'hFFFF_FFFF) perf_lines <= perf_lines + 1'b1;
            if (if_valid && !if_ready && perf_stalls != 32'hFFFF_FFFF)
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`else
    assign perf_lines  = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory (latency 5).
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [63:0] LINE0  = 64'h1111_2222_3333_E188;
    localparam logic [63:0] LINE8  = 64'h4444_5555_6666_0C70;
    localparam logic [63:0] LINE10 = 64'h7777_8888_9999_CF8A;
    localparam logic [63:0] BAD    = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic [63:0] imem_ins = BAD;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [15:0] if_pc;
    logic [63:0] if_instr;
    logic [31:0] perf_lines;
    logic [31:0] perf_stalls;

    int checks = 0;
    int fails  = 0;
    int ecount = 0;

    fetch_stage #(.MEM_LATENCY(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_ins       (imem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .perf_lines     (perf_lines),
        .perf_stalls    (perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_line(input logic [15:0] a);
        case (a)
            16'h0000: return LINE0;
            16'h0008: return LINE8;
            16'h0010: return LINE10;
            default:  return {16'hA5A5, a, ~a, a};
        endcase
    endfunction

    // Memory: output valid only in the 5th cycle after the address settles, then every 5.
    logic [15:0] maddr;
    int          mcnt = 0;
    always @(negedge clk) begin
        if (imem_addr !== maddr) begin
            maddr = imem_addr;
            mcnt  = 0;
        end else begin
            mcnt = (mcnt == 5) ? 1 : mcnt + 1;
        end
        imem_ins = (mcnt == 5) ? mem_line(maddr) : BAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic tick_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ecount = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_pc", 64'(if_pc), 64'h0);
        check("rst_instr", if_instr, 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h0008);
        check("rst_perf_lines", 64'(perf_lines), 64'd0);
        rst_n = 1'b1;
        ecount = 0;

        // First lines, decode always ready
        tick();
        check("park_addr", 64'(imem_addr), 64'h0000);
        tick_to(6);
        check("first_not_early", 64'(if_valid), 64'd0);
        tick_to(7);
        check("first_valid", 64'(if_valid), 64'd1);
        check("first_pc", 64'(if_pc), 64'h0000);
        check("first_instr", 64'(if_instr[15:0]), 64'hE188);
        check("first_next_addr", 64'(imem_addr), 64'h0008);
        tick_to(13);
        check("second_valid", 64'(if_valid), 64'd1);
        check("second_pc", 64'(if_pc), 64'h0008);
        check("second_instr", 64'(if_instr[15:0]), 64'h0C70);

        // Back-pressure for 12 cycles holding 0x0008
        if_ready = 1'b0;
        tick_to(19);
        check("hold_valid", 64'(if_valid), 64'd1);
        check("hold_pc", 64'(if_pc), 64'h0008);
        check("hold_instr", if_instr, LINE8);
        check("hold_addr", 64'(imem_addr), 64'h0010);
        tick_to(25);
        check("hold_pc_late", 64'(if_pc), 64'h0008);
        if_ready = 1'b1;
        tick_to(26);
        check("release_xfer", 64'(if_valid), 64'd0);
        tick_to(28);
        check("release_wait", 64'(if_valid), 64'd0);
        tick_to(29);
        check("third_valid", 64'(if_valid), 64'd1);
        check("third_pc", 64'(if_pc), 64'h0010);
        check("third_instr", 64'(if_instr[15:0]), 64'hCF8A);
        check("perf_stalls_12", 64'(perf_stalls), PERF ? 64'd12 : 64'd0);
        check("perf_lines_3", 64'(perf_lines), PERF ? 64'd3 : 64'd0);

        // Enter HOLD again, then reset in the middle of it
        if_ready = 1'b0;
        tick_to(36);
        check("hold2_pc", 64'(if_pc), 64'h0010);
        check("hold2_addr", 64'(imem_addr), 64'h0018);
        check("perf_stalls_19", 64'(perf_stalls), PERF ? 64'd19 : 64'd0);
        if_ready = 1'b1;
        do_reset();
        check("midrst_valid", 64'(if_valid), 64'd0);
        check("midrst_addr", 64'(imem_addr), 64'h0008);
        check("midrst_perf_stalls", 64'(perf_stalls), 64'd0);
        check("midrst_perf_lines", 64'(perf_lines), 64'd0);
        tick_to(6);
        check("restart_not_early", 64'(if_valid), 64'd0);
        tick_to(7);
        check("restart_valid", 64'(if_valid), 64'd1);
        check("restart_instr", if_instr, LINE0);

        // Redirect to 0x0013 two cycles into the fetch of 0x0008
        tick_to(8);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0013;
        tick();
        redirect_valid = 1'b0;
        check("redir_addr", 64'(imem_addr), 64'h0010);
        check("redir_valid", 64'(if_valid), 64'd0);
        for (int i = 10; i <= 14; i++) begin
            tick_to(i);
            check("redir_no_0008", 64'(if_valid), 64'd0);
        end
        tick_to(15);
        check("redir_line_valid", 64'(if_valid), 64'd1);
        check("redir_line_pc", 64'(if_pc), 64'h0010);
        check("redir_line_instr", if_instr, LINE10);

        // Redirect onto the in-flight address keeps the phase
        do_reset();
        tick_to(8);
        redirect_valid = 1'b1;
        redirect_pc = 16'h000D;
        tick();
        redirect_valid = 1'b0;
        check("same_addr", 64'(imem_addr), 64'h0008);
        tick_to(12);
        check("same_not_early", 64'(if_valid), 64'd0);
        tick_to(13);
        check("same_valid", 64'(if_valid), 64'd1);
        check("same_pc", 64'(if_pc), 64'h0008);
        check("same_instr", if_instr, LINE8);

        // Wrap from 0xFFF8 to 0x0000
        tick_to(14);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", 64'(imem_addr), 64'hFFF8);
        tick_to(20);
        check("wrap_not_early", 64'(if_valid), 64'd0);
        tick_to(21);
        check("wrap_valid", 64'(if_valid), 64'd1);
        check("wrap_pc", 64'(if_pc), 64'hFFF8);
        check("wrap_instr", if_instr, 64'hA5A5_FFF8_0007_FFF8);
        check("wrap_next_addr", 64'(imem_addr), 64'h0000);
        tick_to(27);
        check("wrap0_valid", 64'(if_valid), 64'd1);
        check("wrap0_pc", 64'(if_pc), 64'h0000);
        check("wrap0_instr", if_instr, LINE0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
